fetch_stage: RTL and testbench

//  IF stage plus IF/ID pipeline register of the 5-stage LEGv8 pipeline.

---
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register for the 5-stage LEGv8 pipeline.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_stage #(
    parameter int unsigned        ADDR_W    = 64,
    parameter int unsigned        INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'hD503201F)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               if_valid,
    output logic               misalign
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_flush
`endif
);

    localparam int unsigned PC_STEP = 4;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] target_pc;

    // The instruction memory is read combinationally at the live PC.
    assign imem_addr = pc;

    // In BOOT the PC register still holds RESET_PC; naming it makes the boot fetch explicit.
    assign fetch_pc  = (state == BOOT) ? RESET_PC : pc;
    assign target_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            if_instr <= NOP_INSTR;
            if_pc    <= '0;
            if_valid <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state    <= RUN;
            misalign <= 1'b0;
            if (redirect) begin
                // The word fetched this cycle is on the wrong path; replace it with a bubble.
                pc       <= target_pc;
                if_instr <= NOP_INSTR;
                if_valid <= 1'b0;
                misalign <= |redirect_pc[1:0];
            end else if (!stall) begin
                pc       <= fetch_pc + ADDR_W'(PC_STEP);
                if_instr <= imem_data;
                if_pc    <= fetch_pc;
                if_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Event counters; a redirect masks a coincident stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch <= '0;
            perf_stall <= '0;
            perf_flush <= '0;
        end else if (redirect) begin
            perf_flush <= perf_flush + CNT_W'(1);
        end else if (stall) begin
            perf_stall <= perf_stall + CNT_W'(1);
        end else begin
            perf_fetch <= perf_fetch + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table through an expected-value queue,
// plus a hand-written stall run that watches the memory address.
module tb_fetch_stage;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'hD503201F;

    logic               clk;
    logic               rst_n;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               stall;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic               if_valid;
    logic               misalign;
`ifdef FETCH_PERF_EN
    logic [31:0]        perf_fetch;
    logic [31:0]        perf_stall;
    logic [31:0]        perf_flush;
`endif

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_valid    (if_valid),
        .misalign    (misalign)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush)
`endif
    );

    // Memory model: word at address a is F8000000 + a (32-bit wrap).
    assign imem_data = 32'hF8000000 + imem_addr[31:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst_n;
        logic              stall;
        logic              redirect;
        logic [ADDR_W-1:0] rpc;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] if_pc;
        logic              valid;
        logic              mis;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  if_pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
        logic               mis;
        logic [31:0]        pf;
        logic [31:0]        ps;
        logic [31:0]        pfl;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp;
    int   n_bad;
    logic [31:0] m_fetch, m_stall, m_flush;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic d, input logic [ADDR_W-1:0] rp,
                       input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] ip,
                       input logic v, input logic m);
        vecs.push_back('{r, s, d, rp, p, ip, v, m});
    endtask

    task automatic check_pop(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: step %0d got 0 entries expected 1", idx);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("pc[%0d]", idx), pc, e.pc);
        chk($sformatf("imem_addr[%0d]", idx), imem_addr, e.pc);
        chk($sformatf("if_valid[%0d]", idx), 64'(if_valid), 64'(e.valid));
        chk($sformatf("if_instr[%0d]", idx), 64'(if_instr), 64'(e.instr));
        chk($sformatf("misalign[%0d]", idx), 64'(misalign), 64'(e.mis));
        if (e.valid) chk($sformatf("if_pc[%0d]", idx), if_pc, e.if_pc);
`ifdef FETCH_PERF_EN
        chk($sformatf("perf_fetch[%0d]", idx), 64'(perf_fetch), 64'(e.pf));
        chk($sformatf("perf_stall[%0d]", idx), 64'(perf_stall), 64'(e.ps));
        chk($sformatf("perf_flush[%0d]", idx), 64'(perf_flush), 64'(e.pfl));
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_fetch = '0;
        m_stall = '0;
        m_flush = '0;
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;

        //   rst stl red rpc                     pc                      if_pc                   v  mis
        add(0, 0, 0, 64'h0,                  64'h0,                  64'h0,                  0, 0);
        add(0, 0, 0, 64'h0,                  64'h0,                  64'h0,                  0, 0);
        add(1, 0, 0, 64'h0,                  64'h4,                  64'h0,                  1, 0);
        add(1, 0, 0, 64'h0,                  64'h8,                  64'h4,                  1, 0);
        add(1, 0, 0, 64'h0,                  64'hC,                  64'h8,                  1, 0);
        add(1, 0, 0, 64'h0,                  64'h10,                 64'hC,                  1, 0);
        add(1, 1, 0, 64'h0,                  64'h10,                 64'hC,                  1, 0);
        add(1, 1, 0, 64'h0,                  64'h10,                 64'hC,                  1, 0);
        add(1, 1, 0, 64'h0,                  64'h10,                 64'hC,                  1, 0);
        add(1, 0, 0, 64'h0,                  64'h14,                 64'h10,                 1, 0);
        add(1, 0, 0, 64'h0,                  64'h18,                 64'h14,                 1, 0);
        add(1, 0, 0, 64'h0,                  64'h1C,                 64'h18,                 1, 0);
        add(1, 0, 0, 64'h0,                  64'h20,                 64'h1C,                 1, 0);
        add(1, 0, 1, 64'h100,                64'h100,                64'h0,                  0, 0);
        add(1, 0, 0, 64'h0,                  64'h104,                64'h100,                1, 0);
        add(1, 1, 1, 64'h40,                 64'h40,                 64'h0,                  0, 0);
        add(1, 1, 0, 64'h0,                  64'h40,                 64'h0,                  0, 0);
        add(1, 0, 0, 64'h0,                  64'h44,                 64'h40,                 1, 0);
        add(1, 0, 1, 64'hFFFFFFFFFFFFFFFC,   64'hFFFFFFFFFFFFFFFC,   64'h0,                  0, 0);
        add(1, 0, 0, 64'h0,                  64'h0,                  64'hFFFFFFFFFFFFFFFC,   1, 0);
        add(1, 0, 1, 64'h103,                64'h100,                64'h0,                  0, 1);
        add(1, 0, 0, 64'h0,                  64'h104,                64'h100,                1, 0);
        add(1, 0, 1, 64'h104,                64'h104,                64'h0,                  0, 0);
        add(1, 0, 0, 64'h0,                  64'h108,                64'h104,                1, 0);
        add(1, 0, 1, 64'h80,                 64'h80,                 64'h0,                  0, 0);
        add(1, 0, 0, 64'h0,                  64'h84,                 64'h80,                 1, 0);
        add(1, 0, 1, 64'h80,                 64'h80,                 64'h0,                  0, 0);
        add(1, 1, 0, 64'h0,                  64'h80,                 64'h0,                  0, 0);
        add(0, 1, 0, 64'h0,                  64'h0,                  64'h0,                  0, 0);
        add(0, 0, 1, 64'h203,                64'h0,                  64'h0,                  0, 0);
        add(1, 0, 0, 64'h0,                  64'h4,                  64'h0,                  1, 0);
        add(1, 0, 0, 64'h0,                  64'h8,                  64'h4,                  1, 0);

        foreach (vecs[i]) begin
            exp_t e;
            @(negedge clk);
            rst_n       = vecs[i].rst_n;
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            if (!vecs[i].rst_n) begin
                m_fetch = '0; m_stall = '0; m_flush = '0;
            end else if (vecs[i].redirect) begin
                m_flush++;
            end else if (vecs[i].stall) begin
                m_stall++;
            end else begin
                m_fetch++;
            end
            e.pc    = vecs[i].pc;
            e.if_pc = vecs[i].if_pc;
            e.valid = vecs[i].valid;
            e.mis   = vecs[i].mis;
            e.instr = vecs[i].valid ? 32'hF8000000 + vecs[i].if_pc[31:0] : NOP;
            e.pf    = m_fetch;
            e.ps    = m_stall;
            e.pfl   = m_flush;
            sb.push_back(e);
            @(posedge clk);
            #1;
            check_pop(i);
        end

        // Long stall at pc=8: the memory address, PC and IF/ID word must not move.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            stall    = 1'b1;
            redirect = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("hold_addr[%0d]", k), imem_addr, 64'h8);
            chk($sformatf("hold_instr[%0d]", k), 64'(if_instr), 64'(32'hF8000004));
            chk($sformatf("hold_valid[%0d]", k), 64'(if_valid), 64'h1);
        end
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("release_pc", pc, 64'hC);
        chk("release_instr", 64'(if_instr), 64'(32'hF8000008));
        chk("release_if_pc", if_pc, 64'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
